// File: rtl/cd_pkg.sv
// Shared types, digit moduli and the load-clamp helper for the mm:ss BCD countdown timer.
package cd_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } cd_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam int CD_SEC_ONES_MOD = 10;
    localparam int CD_SEC_TENS_MOD = 6;
    localparam int CD_MIN_ONES_MOD = 10;
    localparam int CD_MIN_TENS_MOD = 10;

    // Out-of-range load digits saturate to the largest legal value of that digit.
    function automatic bcd_digit_t clamp_digit(input bcd_digit_t d, input int modulus);
        if (int'(d) >= modulus) begin
            return bcd_digit_t'(modulus - 1);
        end
        return d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with modulus MOD; chained through brw_in/brw_nxt.
module bcd_down_digit
    import cd_pkg::*;
#(
    parameter int MOD = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       brw_in,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       clr,
    output logic [3:0] cnt,
    output logic       zero,
    output logic       brw_nxt
);

    bcd_digit_t cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = clamp_digit(ld_val, MOD);
        end else if (brw_in) begin
            cnt_d = (cnt_q == 4'd0) ? bcd_digit_t'(MOD - 1) : cnt_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign zero    = (cnt_q == 4'd0);
    assign brw_nxt = brw_in & zero;

endmodule

// File: rtl/bcd_countdown.sv
// Four-digit mm:ss BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control.
// Optional CD_AUTO_RELOAD_EN: reload from a load shadow on expiry instead of alarming.
module bcd_countdown
    import cd_pkg::*;
#(
    parameter int SEC_TENS_MOD = CD_SEC_TENS_MOD,
    parameter int MIN_TENS_MOD = CD_MIN_TENS_MOD
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic        ld,
    input  logic [15:0] ld_val,
    input  logic        start,
    input  logic        stop,
    input  logic        clr,
    output logic [15:0] cnt,
    output logic        running,
    output logic        expired,
    output logic        alarm
);

    cd_state_t   state_q, state_d;
    logic        expired_q;
    logic        decEn, acceptLd, reachZero, reload, reloadOk;
    logic        lastSec, allZero, underflow;
    logic        digitLd, digitClr;
    logic [15:0] clampedLd, reloadVal, digitVal;
    logic [4:0]  brw;
    logic [3:0]  zero;

    assign clampedLd = {clamp_digit(ld_val[15:12], MIN_TENS_MOD),
                        clamp_digit(ld_val[11:8],  CD_MIN_ONES_MOD),
                        clamp_digit(ld_val[7:4],   SEC_TENS_MOD),
                        clamp_digit(ld_val[3:0],   CD_SEC_ONES_MOD)};

    assign decEn     = (state_q == RUN) & tick & ~clr & ~stop;
    assign lastSec   = (cnt[3:0] == 4'd1) & zero[1] & zero[2] & zero[3];
    assign allZero   = &zero;
    // A borrow out of the top digit means RUN was entered holding 00:00; treat it as expiry.
    assign underflow = brw[4];

`ifdef CD_AUTO_RELOAD_EN
    logic [15:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (clr) begin
            shadow_d = '0;
        end else if (acceptLd) begin
            shadow_d = clampedLd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign reloadOk  = (shadow_q != 16'h0000);
    assign reloadVal = shadow_q;
`else
    assign reloadOk  = 1'b0;
    assign reloadVal = '0;
`endif

    always_comb begin
        state_d   = state_q;
        acceptLd  = 1'b0;
        reachZero = 1'b0;
        reload    = 1'b0;
        if (clr) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ld) begin
                        acceptLd = 1'b1;
                    end else if (!stop && start && !allZero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (decEn && (lastSec || underflow)) begin
                        reachZero = 1'b1;
                        if (reloadOk && !underflow) begin
                            reload = 1'b1;
                        end else begin
                            state_d = EXPIRED;
                        end
                    end
                end
                PAUSE: begin
                    if (ld) begin
                        acceptLd = 1'b1;
                    end else if (!stop && start) begin
                        state_d = RUN;
                    end
                end
                EXPIRED: state_d = EXPIRED;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            expired_q <= reachZero;
        end
    end

    assign digitLd  = acceptLd | reload;
    assign digitVal = reload ? reloadVal : clampedLd;
    assign digitClr = clr | underflow;
    assign brw[0]   = decEn;

    bcd_down_digit #(.MOD(CD_SEC_ONES_MOD)) u_sec_ones (
        .clk(clk), .rst_n(rst_n), .brw_in(brw[0]), .ld(digitLd), .ld_val(digitVal[3:0]),
        .clr(digitClr), .cnt(cnt[3:0]), .zero(zero[0]), .brw_nxt(brw[1])
    );

    bcd_down_digit #(.MOD(SEC_TENS_MOD)) u_sec_tens (
        .clk(clk), .rst_n(rst_n), .brw_in(brw[1]), .ld(digitLd), .ld_val(digitVal[7:4]),
        .clr(digitClr), .cnt(cnt[7:4]), .zero(zero[1]), .brw_nxt(brw[2])
    );

    bcd_down_digit #(.MOD(CD_MIN_ONES_MOD)) u_min_ones (
        .clk(clk), .rst_n(rst_n), .brw_in(brw[2]), .ld(digitLd), .ld_val(digitVal[11:8]),
        .clr(digitClr), .cnt(cnt[11:8]), .zero(zero[2]), .brw_nxt(brw[3])
    );

    bcd_down_digit #(.MOD(MIN_TENS_MOD)) u_min_tens (
        .clk(clk), .rst_n(rst_n), .brw_in(brw[3]), .ld(digitLd), .ld_val(digitVal[15:12]),
        .clr(digitClr), .cnt(cnt[15:12]), .zero(zero[3]), .brw_nxt(brw[4])
    );

    assign running = (state_q == RUN);
    assign alarm   = (state_q == EXPIRED);
    assign expired = expired_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Directed self-checking bench for bcd_countdown; covers CD_AUTO_RELOAD_EN when defined.
module tb_bcd_countdown;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        tick   = 1'b0;
    logic        ld     = 1'b0;
    logic [15:0] ld_val = '0;
    logic        start  = 1'b0;
    logic        stop   = 1'b0;
    logic        clr    = 1'b0;
    logic [15:0] cnt;
    logic        running;
    logic        expired;
    logic        alarm;

    int checkCount = 0;
    int errorCount = 0;

    always #5 clk = ~clk;

    bcd_countdown dut (
        .clk(clk), .rst_n(rst_n), .tick(tick), .ld(ld), .ld_val(ld_val),
        .start(start), .stop(stop), .clr(clr),
        .cnt(cnt), .running(running), .expired(expired), .alarm(alarm)
    );

    task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] required);
        checkCount++;
        if (actual !== required) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, required %h", tag, actual, required);
        end
    endtask

    task automatic checkFlags(input string tag, input logic runV, input logic expV, input logic almV);
        checkOutput({tag, ".running"}, {15'd0, running}, {15'd0, runV});
        checkOutput({tag, ".expired"}, {15'd0, expired}, {15'd0, expV});
        checkOutput({tag, ".alarm"},   {15'd0, alarm},   {15'd0, almV});
    endtask

    // Holds the given inputs across one rising edge, then samples 1 ns after it.
    task automatic applyStimulus(input logic tickV, input logic ldV, input logic [15:0] valV,
                                 input logic startV, input logic stopV, input logic clrV);
        tick   = tickV;
        ld     = ldV;
        ld_val = valV;
        start  = startV;
        stop   = stopV;
        clr    = clrV;
        @(posedge clk);
        #1;
        tick  = 1'b0;
        ld    = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic doLoad(input logic [15:0] v);  applyStimulus(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0); endtask
    task automatic doStart();                     applyStimulus(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0); endtask
    task automatic doTick();                      applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); endtask
    task automatic doClr();                       applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1); endtask
    task automatic doIdle();                      applyStimulus(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0); endtask

    initial begin
        #12;
        checkOutput("reset.cnt", cnt, 16'h0000);
        checkFlags("reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        doIdle();

        $display("[TB] borrow chain");
        doLoad(16'h1000);
        doStart();
        doTick();
        checkOutput("borrow.1000", cnt, 16'h0959);
        doClr();
        doLoad(16'h0100);
        doStart();
        doTick();
        checkOutput("borrow.0100", cnt, 16'h0059);
        doClr();
        checkOutput("clr.cnt", cnt, 16'h0000);

        $display("[TB] load clamp");
        doLoad(16'h7A6F);
        checkOutput("clamp.7A6F", cnt, 16'h7959);
        doLoad(16'hFFFF);
        checkOutput("clamp.FFFF", cnt, 16'h9959);
        applyStimulus(1'b0, 1'b1, 16'h0042, 1'b0, 1'b0, 1'b1);
        checkOutput("clr_over_ld", cnt, 16'h0000);
        doStart();
        checkFlags("start_zero", 1'b0, 1'b0, 1'b0);

        $display("[TB] pause and resume");
        doLoad(16'h0010);
        doStart();
        checkFlags("run10", 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
        checkOutput("stop_tick.cnt", cnt, 16'h0010);
        checkFlags("stop_tick", 1'b0, 1'b0, 1'b0);
        doTick();
        checkOutput("pause_tick.cnt", cnt, 16'h0010);
        doLoad(16'h0020);
        checkOutput("pause_ld.cnt", cnt, 16'h0020);
        doStart();
        checkFlags("resume", 1'b1, 1'b0, 1'b0);
        doTick();
        checkOutput("resume_tick.cnt", cnt, 16'h0019);
        doClr();

        $display("[TB] start with tick, load while running");
        doLoad(16'h0002);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
        checkOutput("start_tick.cnt", cnt, 16'h0002);
        checkFlags("start_tick", 1'b1, 1'b0, 1'b0);
        doLoad(16'h0050);
        checkOutput("run_ld.cnt", cnt, 16'h0002);
        doTick();
        checkOutput("run_tick.cnt", cnt, 16'h0001);
        doClr();

`ifdef CD_AUTO_RELOAD_EN
        $display("[TB] auto reload");
        doLoad(16'h0002);
        doStart();
        doTick();
        checkOutput("reload.t1", cnt, 16'h0001);
        checkFlags("reload.t1", 1'b1, 1'b0, 1'b0);
        doTick();
        checkOutput("reload.t2", cnt, 16'h0002);
        checkFlags("reload.t2", 1'b1, 1'b1, 1'b0);
        doTick();
        checkOutput("reload.t3", cnt, 16'h0001);
        checkFlags("reload.t3", 1'b1, 1'b0, 1'b0);
        doTick();
        checkOutput("reload.t4", cnt, 16'h0002);
        checkFlags("reload.t4", 1'b1, 1'b1, 1'b0);
        doClr();
        checkFlags("reload.clr", 1'b0, 1'b0, 1'b0);
`else
        $display("[TB] expiry");
        doLoad(16'h0003);
        doStart();
        doTick();
        checkOutput("exp.t1", cnt, 16'h0002);
        doTick();
        checkOutput("exp.t2", cnt, 16'h0001);
        checkFlags("exp.t2", 1'b1, 1'b0, 1'b0);
        doTick();
        checkOutput("exp.t3", cnt, 16'h0000);
        checkFlags("exp.t3", 1'b0, 1'b1, 1'b1);
        doIdle();
        checkFlags("exp.after", 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 16'h0033, 1'b1, 1'b0, 1'b0);
        checkOutput("exp.ignore.cnt", cnt, 16'h0000);
        checkFlags("exp.ignore", 1'b0, 1'b0, 1'b1);
        doClr();
        checkOutput("exp.clr.cnt", cnt, 16'h0000);
        checkFlags("exp.clr", 1'b0, 1'b0, 1'b0);
`endif

        $display("[TB] reset mid-count");
        doLoad(16'h0005);
        doStart();
        checkFlags("pre_reset", 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("mid_reset.cnt", cnt, 16'h0000);
        checkFlags("mid_reset", 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
        checkFlags("in_reset", 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        doTick();
        checkOutput("post_reset.cnt", cnt, 16'h0000);
        checkFlags("post_reset", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/bcd_countdown.md
Name: bcd_countdown

Overview:
- Four-digit BCD mm:ss countdown timer for the alarm clock's snooze and kitchen-timer functions.
- Loaded with a start time, it decrements once per external 1 Hz tick enable, using a per-digit borrow chain that runs from the seconds digit up to the minutes digit.
- Raises an expiry pulse and a held alarm flag when it reaches 00:00.
- Sits beside the up-counting time-of-day chain, fed by the same tick prescaler, and drives the display mux and alarm FSM.

Parameters:
- SEC_TENS_MOD, 6, modulus of the seconds-tens digit (legal values 0..5).
- MIN_TENS_MOD, 10, modulus of the minutes-tens digit (legal values 0..9; maximum time 99:59).

Ports:
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous active-low reset.
- tick  input  1  one-clk enable pulse at 1 Hz; decrements the count when the FSM is in RUN.
- ld  input  1  load strobe.
- ld_val  input  16  BCD load value {min_tens, min_ones, sec_tens, sec_ones}.
- start  input  1  begin or resume counting.
- stop  input  1  pause counting.
- clr  input  1  abort or acknowledge; zeroes the count and returns to IDLE.
- cnt  output  16  current BCD count, same digit order as ld_val.
- running  output  1  high while state is RUN.
- expired  output  1  one-clk pulse when the count reaches 00:00.
- alarm  output  1  held high while state is EXPIRED.

Behaviour:
- Reset (async, rst_n low):
  - cnt=16'h0000, state=IDLE.
  - running=0, expired=0, alarm=0.
- FSM states: IDLE, RUN, PAUSE, EXPIRED. All outputs are registered or decoded from registered state.
- Input priority within a cycle: clr > ld > stop > start > tick.
- IDLE:
  - ld → cnt<=ld_val (clamped, see below); remain in IDLE.
  - start with cnt≠0 → RUN.
  - start with cnt==0 → ignored.
- RUN:
  - tick → cnt decrements by one second on that edge.
  - Decrement reaches 0000 → go to EXPIRED on the same edge; expired=1 for exactly the following cycle.
  - stop → PAUSE; cnt unchanged, and a coincident tick is dropped.
  - ld and start → ignored.
- PAUSE:
  - start → RUN.
  - ld → cnt<=ld_val; remain in PAUSE.
  - tick → ignored.
- EXPIRED:
  - alarm=1 and cnt=0000.
  - Only clr leaves this state (→ IDLE). All other inputs are ignored.
- clr in any state → IDLE, cnt<=0000, next cycle alarm=0.
- Decrement arithmetic, per digit:
  - A digit decrements when its borrow-in is high.
  - Digit at 0 with borrow-in → wraps to MOD-1 and asserts borrow-out.
  - Seconds-ones borrow-in = tick & RUN.
  - Examples: 10:00 → 09:59; 01:00 → 00:59.
- Load clamp:
  - Any ld_val digit ≥ its modulus loads as MOD-1. Example: 16'h7A6F loads as 79:59.
  - Illegal digits never reach the counters.
- Tick latency: cnt reflects the decrement in the cycle after the tick edge.
- start and tick in the same cycle from IDLE/PAUSE → enter RUN only; the first decrement waits for the next tick.
- Reset asserted mid-count → immediate return to reset values; no expired pulse.

Optional Feature:
- Macro: CD_AUTO_RELOAD_EN.
- Defined:
  - A shadow register captures the clamped value on each accepted ld.
  - On reaching 0000 in RUN, expired pulses as normal, but the FSM stays in RUN and cnt reloads from shadow on the same edge. alarm is never asserted.
  - If the shadow is 0000, behaviour is as if undefined.
  - clr also zeroes the shadow.
- Undefined: no shadow register; behaviour exactly as described above.

Decomposition:
- Package cd_pkg:
  - typedef enum logic [1:0] cd_state_t {IDLE, RUN, PAUSE, EXPIRED}.
  - localparams for digit moduli.
  - 4-bit BCD digit typedef.
- Sub-module bcd_down_digit, parameter MOD:
  - Ports: clk, rst_n, brw_in, ld, ld_val[3:0], clr, cnt[3:0], zero, brw_nxt.
  - brw_nxt = brw_in & (cnt==0).
  - Instantiate four times as a borrow chain.
  - Expiry is detected as all four zero flags set after the decrement.

Test Plan:
- Reset with rst_n=0 mid-RUN at 00:05 → cnt=0000, running=0, alarm=0, expired never pulsed.
- ld 16'h0003, start, 3 ticks → cnt 0002, 0001, 0000; expired high one clk after third tick; alarm=1; a further tick leaves cnt at 0000.
- ld 16'h1000, start, 1 tick → cnt=16'h0959; ld 16'h0100, start, 1 tick → cnt=16'h0059.
- ld 16'h7A6F → cnt=16'h7959; start with cnt=0000 in IDLE → state stays IDLE, running=0.
- RUN at 00:10, stop+tick same cycle → PAUSE with cnt=0010; ld 16'h0020 in PAUSE → cnt=0020; start → RUN; clr during EXPIRED → IDLE, alarm=0.
- With CD_AUTO_RELOAD_EN: ld 16'h0002, start, 4 ticks → cnt 0001, 0000→reload 0002 (expired pulse, running stays 1), then 0001, 0002 never skipped; alarm stays 0.
